// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multicycle MIPS controller.
// States, opcodes, functs and datapath select encodings.
package multicycle_control_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_MUL = 6'b011000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_NONE,
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       pcwrite;
    logic       branch;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction fields in, datapath strobes out.
// master = controller side, slave = datapath side.
interface multicycle_control_if;

  logic [5:0] Op;
  logic [5:0] Funct;
  logic       zeroflag;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       PCWrite;
  logic       Branch;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  modport master (
    input  Op, Funct, zeroflag,
    output IorD, MemWrite, IRWrite,
    output RegDst, MemtoReg, RegWrite,
    output ALUSrcA, PCWrite, Branch,
    output ALUSrcB, PCSrc, PCEn,
    output ALUControl, state_o
  );

  modport slave (
    output Op, Funct, zeroflag,
    input  IorD, MemWrite, IRWrite,
    input  RegDst, MemtoReg, RegWrite,
    input  ALUSrcA, PCWrite, Branch,
    input  ALUSrcB, PCSrc, PCEn,
    input  ALUControl, state_o
  );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU op plus funct to ALUControl; funct_ok flags
// whether the funct names a supported operation.
module alu_decoder
  import multicycle_control_pkg::*;
#(
  parameter bit ENABLE_MUL = 1'b1
) (
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_ok
);

  logic [2:0] fctl;

  always_comb begin
    fctl     = ALU_AND;
    funct_ok = 1'b1;
    unique case (funct)
      F_ADD: fctl = ALU_ADD;
      F_SUB: fctl = ALU_SUB;
      F_AND: fctl = ALU_AND;
      F_OR:  fctl = ALU_OR;
      F_SLT: fctl = ALU_SLT;
      F_MUL: begin
        if (ENABLE_MUL) fctl = ALU_MUL;
        else funct_ok = 1'b0;
      end
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = ALU_AND;
    unique case (aluop)
      ALUOP_ADD:   alucontrol = ALU_ADD;
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = fctl;
      default:     alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: Moore state decode plus
// combinational ALU decode and PC enable.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit ENABLE_MUL = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  logic [3:0] state;
  logic [3:0] state_n;
  ctrl_t      c;
  aluop_t     aluop;
  logic       funct_ok;
  logic [2:0] alucontrol;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n = S_FETCH;
    unique case (state)
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (bus.Op == OP_LW),
          (bus.Op == OP_SW):    state_n = S_MEMADR;
          (bus.Op == OP_RTYPE): state_n = S_EXECUTE;
          (bus.Op == OP_BEQ):   state_n = S_BRANCH;
          (bus.Op == OP_ADDI):  state_n = S_ADDIEX;
          (bus.Op == OP_J):     state_n = S_JUMP;
          default:              state_n = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_n = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_n = S_MEMWB;
      S_EXECUTE: state_n = S_ALUWB;
      S_ADDIEX:  state_n = S_ADDIWB;
      default:   state_n = S_FETCH;
    endcase
  end

  always_comb begin
    c     = '0;
    aluop = ALUOP_NONE;
    unique case (state)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = SRCB_FOUR;
        aluop     = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_IMMSH;
        aluop     = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        aluop     = ALUOP_ADD;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        aluop     = ALUOP_FUNCT;
      end
      // unsupported functs must not retire a result
      S_ALUWB: begin
        c.regwrite = funct_ok;
        c.regdst   = 1'b1;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.branch  = 1'b1;
        c.pcsrc   = PC_ALUOUT;
        aluop     = ALUOP_SUB;
      end
      S_JUMP: begin
        c.pcwrite = 1'b1;
        c.pcsrc   = PC_JUMP;
      end
      default: c = '0;
    endcase
  end

  alu_decoder #(
    .ENABLE_MUL(ENABLE_MUL)
  ) u_alu_decoder (
    .aluop     (aluop),
    .funct     (bus.Funct),
    .alucontrol(alucontrol),
    .funct_ok  (funct_ok)
  );

  assign bus.IorD       = c.iord;
  assign bus.MemWrite   = c.memwrite;
  assign bus.IRWrite    = c.irwrite;
  assign bus.RegDst     = c.regdst;
  assign bus.MemtoReg   = c.memtoreg;
  assign bus.RegWrite   = c.regwrite;
  assign bus.ALUSrcA    = c.alusrca;
  assign bus.PCWrite    = c.pcwrite;
  assign bus.Branch     = c.branch;
  assign bus.ALUSrcB    = c.alusrcb;
  assign bus.PCSrc      = c.pcsrc;
  assign bus.PCEn       = c.pcwrite
                        | (c.branch & bus.zeroflag);
  assign bus.ALUControl = alucontrol;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed plus randomized bench for multicycle_control,
// both ENABLE_MUL settings, against a table-driven model.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  multicycle_control_if b1 ();
  multicycle_control_if b2 ();

  multicycle_control #(.ENABLE_MUL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  multicycle_control #(.ENABLE_MUL(1'b0)) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  logic [16:0] o1, o2;
  assign o1 = {b1.IorD, b1.MemWrite, b1.IRWrite,
               b1.RegDst, b1.MemtoReg, b1.RegWrite,
               b1.ALUSrcA, b1.PCWrite, b1.Branch,
               b1.ALUSrcB, b1.PCSrc, b1.PCEn,
               b1.ALUControl};
  assign o2 = {b2.IorD, b2.MemWrite, b2.IRWrite,
               b2.RegDst, b2.MemtoReg, b2.RegWrite,
               b2.ALUSrcA, b2.PCWrite, b2.Branch,
               b2.ALUSrcB, b2.PCSrc, b2.PCEn,
               b2.ALUControl};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic drive(input logic [5:0] op,
                       input logic [5:0] fn,
                       input logic zf);
    b1.Op = op; b1.Funct = fn; b1.zeroflag = zf;
    b2.Op = op; b2.Funct = fn; b2.zeroflag = zf;
  endtask

  // {known, ALUControl} for an R-type funct
  function automatic logic [3:0] fmodel(
    input logic [5:0] fn, input bit mul);
    case (fn)
      6'b100000: return 4'b1_010;
      6'b100010: return 4'b1_100;
      6'b100100: return 4'b1_000;
      6'b100101: return 4'b1_001;
      6'b101010: return 4'b1_110;
      6'b011000: return mul ? 4'b1_101 : 4'b0_000;
      default:   return 4'b0_000;
    endcase
  endfunction

  function automatic int lat(input logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  // state number visited in cycle k of an instruction
  function automatic int st_at(input logic [5:0] op,
                               input int k);
    int lw[5], sw[4], rt[4], ad[4], bq[3], jp[3];
    lw = '{0, 1, 2, 3, 4};
    sw = '{0, 1, 2, 5};
    rt = '{0, 1, 6, 7};
    ad = '{0, 1, 9, 10};
    bq = '{0, 1, 8};
    jp = '{0, 1, 11};
    case (op)
      6'b100011: return lw[k];
      6'b101011: return sw[k];
      6'b000000: return rt[k];
      6'b001000: return ad[k];
      6'b000100: return bq[k];
      6'b000010: return jp[k];
      default:   return k;
    endcase
  endfunction

  function automatic logic [16:0] model(
    input int st, input logic [5:0] fn,
    input logic zf, input bit mul);
    logic iord, mw, irw, rd, m2r, rw, sa, pcw, br;
    logic [1:0] sb, ps;
    logic [2:0] ctl;
    logic [3:0] f;
    {iord, mw, irw, rd, m2r, rw, sa, pcw, br} = '0;
    sb = 2'b00; ps = 2'b00; ctl = 3'b000;
    f = fmodel(fn, mul);
    case (st)
      0: begin irw = 1; pcw = 1; sb = 2'b01; ctl = 3'b010; end
      1: begin sb = 2'b11; ctl = 3'b010; end
      2, 9: begin sa = 1; sb = 2'b10; ctl = 3'b010; end
      3: iord = 1;
      4: begin rw = 1; m2r = 1; end
      5: begin iord = 1; mw = 1; end
      6: begin sa = 1; ctl = f[2:0]; end
      7: begin rw = f[3]; rd = 1; end
      8: begin sa = 1; br = 1; ps = 2'b01; ctl = 3'b100; end
      10: rw = 1;
      11: begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {iord, mw, irw, rd, m2r, rw, sa, pcw, br,
            sb, ps, pcw | (br & zf), ctl};
  endfunction

  // runs ncyc cycles of an instruction (0 = all of it)
  task automatic exec(input logic [5:0] op,
                      input logic [5:0] fn,
                      input logic zf,
                      input string tag,
                      input int ncyc = 0);
    int n;
    n = (ncyc == 0) ? lat(op) : ncyc;
    for (int k = 0; k < n; k++) begin
      int st;
      logic [5:0] opv, fnv;
      logic zfv;
      st  = st_at(op, k);
      opv = (st == 1 || st == 2) ? op : 6'($urandom);
      fnv = (st == 6 || st == 7) ? fn : 6'($urandom);
      zfv = (st == 8) ? zf : 1'($urandom);
      @(negedge clk);
      drive(opv, fnv, zfv);
      #1;
      chk($sformatf("%s_c%0d_st", tag, k),
          32'(b1.state_o), st);
      chk($sformatf("%s_c%0d_out", tag, k),
          32'(o1), 32'(model(st, fn, zfv, 1'b1)));
      chk($sformatf("%s_c%0d_out_nomul", tag, k),
          32'(o2), 32'(model(st, fn, zfv, 1'b0)));
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000,
                      6'b000100, 6'b001000, 6'b000010};
  endfunction

  initial begin
    logic [5:0] op, fn;
    logic [5:0] fns[7];
    logic [5:0] ops[6];
    logic [31:0] lwi;
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b101010, 6'b011000, 6'b111111};
    ops = '{6'b100011, 6'b101011, 6'b000000,
            6'b000100, 6'b001000, 6'b000010};
    lwi = 32'h8C080004;
    drive(6'b100011, 6'b0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_state", 32'(b1.state_o), 0);
    chk("rst_out", 32'(o1), 32'(model(0, 6'd0, 0, 1)));
    chk("rst_out_nomul", 32'(o2),
        32'(model(0, 6'd0, 0, 0)));
    @(posedge clk); #1 rst = 1'b0;

    // reset asserted in MEMRD of a lw
    exec(6'b100011, 6'b0, 1'b0, "lw_part", 4);
    #1 rst = 1'b1;
    #1;
    chk("midrst_state", 32'(b1.state_o), 0);
    chk("midrst_out", 32'(o1),
        32'(model(0, 6'd0, 0, 1)));
    @(posedge clk); #1;
    chk("midrst_hold", 32'(b1.state_o), 0);
    rst = 1'b0;
    exec(lwi[31:26], lwi[5:0], 1'b0, "lw");

    exec(6'b000000, 6'b100010, 1'b0, "rsub");
    exec(6'b000100, 6'b000000, 1'b1, "beq_t");
    exec(6'b000100, 6'b000000, 1'b0, "beq_nt");
    exec(6'b000000, 6'b111111, 1'b0, "rbad");
    exec(6'b000000, 6'b011000, 1'b0, "rmul");
    exec(6'b111111, 6'b000000, 1'b0, "illegal");
    exec(6'b000010, 6'b000000, 1'b0, "j");
    exec(6'b101011, 6'b000000, 1'b0, "sw");
    exec(6'b001000, 6'b000000, 1'b0, "addi");

    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 6);
      if (r < 6) op = ops[r];
      else begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end
      fn = ($urandom_range(0, 3) == 0)
         ? 6'($urandom) : fns[$urandom_range(0, 6)];
      exec(op, fn, 1'($urandom), $sformatf("rnd%0d", i));
    end

    @(negedge clk); #1;
    chk("end_fetch", 32'(b1.state_o), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
